// File: rtl/score_keeper_if.sv
// Bundle between the match controller, the physics engine and the display stage.
// Clock and reset stay plain ports on the modules.
interface score_keeper_if;
  logic       tick;
  logic       start;
  logic       valid;
  logic       game_over;
  logic [1:0] winner;
  logic       run;
  logic       new_match;
  logic       point_pulse;
  logic [6:0] p1_score;
  logic [6:0] p2_score;
  logic [7:0] p1_bcd;
  logic [7:0] p2_bcd;
  logic [1:0] state;
  logic [1:0] match_winner;

  modport master (
    output tick, start, valid, game_over, winner,
    input  run, new_match, point_pulse, p1_score, p2_score,
    input  p1_bcd, p2_bcd, state, match_winner
  );

  modport slave (
    input  tick, start, valid, game_over, winner,
    output run, new_match, point_pulse, p1_score, p2_score,
    output p1_bcd, p2_bcd, state, match_winner
  );
endinterface

// File: rtl/score_keeper.sv
// Match controller: counts points from physics results, gates the frame tick with
// a serve pause after each point, and declares the match winner at WIN_SCORE.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 90
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0] p1_bcd_q, p1_bcd_d, p2_bcd_q, p2_bcd_d;
  logic [1:0] mw_q, mw_d;
  logic       armed_q, armed_d;
  logic       start_q;
  logic       run_q, run_d;
  logic       new_match_q, new_match_d;
  logic       point_q, point_d;

  logic       start_rise;
  logic       winner_ok;
  logic       pt;
  logic [6:0] p1_inc, p2_inc;

  // Decimal increment of a {tens, ones} pair; keeps BCD in lockstep with binary.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign start_rise = bus.start & ~start_q;
  assign winner_ok  = (bus.winner == 2'd1) | (bus.winner == 2'd2);
  assign pt         = (state_q == PLAY) & bus.valid & bus.game_over & armed_q & winner_ok;
  assign p1_inc     = p1_q + 7'd1;
  assign p2_inc     = p2_q + 7'd1;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p1_bcd_d    = p1_bcd_q;
    p2_bcd_d    = p2_bcd_q;
    mw_d        = mw_q;
    armed_d     = armed_q;
    new_match_d = 1'b0;
    point_d     = 1'b0;

    // A clean physics frame re-arms in any state; pt needs game_over so never collides.
    if (bus.valid & ~bus.game_over) armed_d = 1'b1;

    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          p1_d        = '0;
          p2_d        = '0;
          p1_bcd_d    = '0;
          p2_bcd_d    = '0;
          mw_d        = '0;
          new_match_d = 1'b1;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (pt) begin
          point_d = 1'b1;
          armed_d = 1'b0;
          if (bus.winner == 2'd1) begin
            p1_d     = p1_inc;
            p1_bcd_d = bcd_inc(p1_bcd_q);
          end else begin
            p2_d     = p2_inc;
            p2_bcd_d = bcd_inc(p2_bcd_q);
          end
          if (((bus.winner == 2'd1) ? p1_inc : p2_inc) == 7'(WIN_SCORE)) begin
            mw_d    = bus.winner;
            state_d = OVER;
          end else begin
            cnt_d   = 8'(PAUSE_FRAMES);
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (bus.tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d = (state_d == PLAY);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p1_bcd_q    <= '0;
      p2_bcd_q    <= '0;
      mw_q        <= '0;
      armed_q     <= 1'b1;
      start_q     <= 1'b0;
      run_q       <= 1'b0;
      new_match_q <= 1'b0;
      point_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p1_bcd_q    <= p1_bcd_d;
      p2_bcd_q    <= p2_bcd_d;
      mw_q        <= mw_d;
      armed_q     <= armed_d;
      start_q     <= bus.start;
      run_q       <= run_d;
      new_match_q <= new_match_d;
      point_q     <= point_d;
    end
  end

  assign bus.run          = run_q;
  assign bus.new_match    = new_match_q;
  assign bus.point_pulse  = point_q;
  assign bus.p1_score     = p1_q;
  assign bus.p2_score     = p2_q;
  assign bus.p1_bcd       = p1_bcd_q;
  assign bus.p2_bcd       = p2_bcd_q;
  assign bus.state        = state_q;
  assign bus.match_winner = mw_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=12 and PAUSE_FRAMES=4;
// expected values are hand-computed constants.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;

  score_keeper_if bus ();

  score_keeper #(.WIN_SCORE(12), .PAUSE_FRAMES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.point_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are sampled on its edge; outputs are read 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic go, input logic [1:0] w);
    bus.valid = 1'b1; bus.game_over = go; bus.winner = w;
    step();
    bus.valid = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1; step();
      bus.tick = 1'b0; step();
    end
  endtask

  // Re-arm with a clean frame, score one point, optionally wait out the pause.
  task automatic give(input logic [1:0] w, input bit pause_after);
    strobe(1'b0, 2'd0);
    strobe(1'b1, w);
    bus.game_over = 1'b0;
    if (pause_after) ticks(4);
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.valid = 0; bus.game_over = 0; bus.winner = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_state", 32'(bus.state), 0);
    check("rst_run", 32'(bus.run), 0);
    check("rst_scores", {bus.p1_score, bus.p2_score}, 0);
    check("rst_bcd", {bus.p1_bcd, bus.p2_bcd}, 0);
    check("rst_mw", 32'(bus.match_winner), 0);
    check("rst_pulses", {bus.new_match, bus.point_pulse}, 0);

    // Start: one-cycle new_match, PLAY with run high
    bus.start = 1'b1; step();
    check("start_nm", 32'(bus.new_match), 1);
    check("start_state", 32'(bus.state), 1);
    check("start_run", 32'(bus.run), 1);
    step();
    check("start_nm_low", 32'(bus.new_match), 0);
    bus.start = 1'b0;

    // P1 point with game_over held across three valid strobes
    bus.valid = 1'b1; bus.game_over = 1'b1; bus.winner = 2'd1; step();
    check("p1_score", 32'(bus.p1_score), 1);
    check("p1_bcd", 32'(bus.p1_bcd), 8'h01);
    check("p1_pulse", 32'(bus.point_pulse), 1);
    check("p1_state", 32'(bus.state), 2);
    check("p1_run", 32'(bus.run), 0);
    bus.valid = 1'b0; step();
    check("p1_pulse_low", 32'(bus.point_pulse), 0);
    strobe(1'b1, 2'd1);
    strobe(1'b1, 2'd1);
    check("p1_once", 32'(bus.p1_score), 1);
    check("pulse_once", pulse_cnt, 1);

    // Pause: still paused after 3 ticks, PLAY on the 4th
    ticks(3);
    check("pause_3", 32'(bus.state), 2);
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    check("pause_4", 32'(bus.state), 1);
    check("pause_run", 32'(bus.run), 1);
    step();

    // Ticks alone did not re-arm: held game_over must not score
    strobe(1'b1, 2'd1);
    check("no_rearm", 32'(bus.p1_score), 1);
    check("no_rearm_st", 32'(bus.state), 1);

    // Re-arm, then winner 0 and 3 are ignored and leave armed set
    strobe(1'b0, 2'd0);
    strobe(1'b1, 2'd0);
    strobe(1'b1, 2'd3);
    check("ign_scores", {bus.p1_score, bus.p2_score}, {7'd1, 7'd0});
    check("ign_state", 32'(bus.state), 1);
    check("ign_pulses", pulse_cnt, 1);
    strobe(1'b1, 2'd2);
    check("p2_after_ign", 32'(bus.p2_score), 1);
    check("p2_pause", 32'(bus.state), 2);

    // Reset mid-PAUSE
    bus.game_over = 1'b0;
    ticks(1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_state", 32'(bus.state), 0);
    check("mid_rst_run", 32'(bus.run), 0);
    check("mid_rst_scores", {bus.p1_score, bus.p2_score}, 0);
    check("mid_rst_bcd", {bus.p1_bcd, bus.p2_bcd}, 0);
    step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check("restart_nm", 32'(bus.new_match), 1);
    check("restart_state", 32'(bus.state), 1);
    step();

    // BCD carry: ten points to P2
    for (int i = 0; i < 10; i++) give(2'd2, 1'b1);
    check("bcd10_score", 32'(bus.p2_score), 10);
    check("bcd10_bcd", 32'(bus.p2_bcd), 8'h10);
    check("bcd10_p1", 32'(bus.p1_score), 0);
    give(2'd2, 1'b1);
    check("bcd11_bcd", 32'(bus.p2_bcd), 8'h11);
    give(2'd2, 1'b0);
    check("win_score", 32'(bus.p2_score), 12);
    check("win_bcd", 32'(bus.p2_bcd), 8'h12);
    check("win_mw", 32'(bus.match_winner), 2);
    check("win_state", 32'(bus.state), 3);
    check("win_run", 32'(bus.run), 0);

    // OVER: physics activity cannot score
    give(2'd1, 1'b0);
    check("over_p1", 32'(bus.p1_score), 0);
    check("over_hold", 32'(bus.match_winner), 2);
    check("pulse_total", pulse_cnt, 14);

    // start_rise coinciding with tick in OVER
    bus.start = 1'b1; bus.tick = 1'b1; step();
    bus.tick = 1'b0;
    check("over_nm", 32'(bus.new_match), 1);
    check("over_state", 32'(bus.state), 1);
    check("over_run", 32'(bus.run), 1);
    check("over_clear", {bus.p2_score, bus.p2_bcd, bus.match_winner}, 0);
    bus.start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match controller directly downstream of the physics engine. It consumes the per-frame `valid` / `game_over` / `winner` outputs and counts points for each player. It gates the 60 Hz frame tick fed back into the physics engine, inserting a serve pause after each point, and declares a match winner at a configurable target score. It also exposes binary and BCD scores to the display stage.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points needed to win the match; legal range 1..99.
- `PAUSE_FRAMES`, default 90: frame ticks to hold after each point (1.5 s at 60 Hz); legal range 1..255.

Ports:
- `clk` input 1: system clock, the same clock as the physics engine.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: raw 60 Hz frame strobe, one `clk` wide.
- `start` input 1: player start button, level; synchronised upstream.
- `valid` input 1: physics per-frame result strobe.
- `game_over` input 1: physics point-ended flag.
- `winner` input 2: physics point winner; 1 = P1, 2 = P2; 0 and 3 are ignored.
- `run` output 1: registered frame enable; the top level drives physics `en = tick & run`.
- `new_match` output 1: one-cycle pulse; the top level ORs it into the physics reset.
- `point_pulse` output 1: one-cycle pulse on each scored point, for sound.
- `p1_score`, `p2_score` output 7: binary scores.
- `p1_bcd`, `p2_bcd` output 8: {tens, ones} BCD of each score.
- `state` output 2: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.
- `match_winner` output 2: 0 none, 1 P1, 2 P2.

## Operation
- `start_q` is registered each cycle. `start_rise = start & ~start_q`.
- Armed flag `armed`: cleared when a point is taken. Set on `valid & ~game_over`. Prevents double counting while `game_over` is held high.
- Point event: `pt = (state==PLAY) & valid & game_over & armed & (winner==1 | winner==2)`.
- Point event with `winner` 0 or 3: ignored entirely. `armed` is unchanged.
- State IDLE: `run`=0. On `start_rise`: clear scores, BCD, and `match_winner`; pulse `new_match`; go to PLAY.
- State PLAY: `run`=1. On `pt`:
  - Increment the winner's score and BCD; pulse `point_pulse`; clear `armed`.
  - If the new score equals `WIN_SCORE`: set `match_winner` = `winner` and go to OVER.
  - Otherwise load pause counter = `PAUSE_FRAMES` and go to PAUSE.
  - `start` is ignored in PLAY.
- State PAUSE: `run`=0. Each `tick` decrements the counter. When `tick` arrives with counter==1, go to PLAY.
  - The physics engine resets the ball on the first enabled frame after the pause.
  - That frame's `valid` arrives with `game_over`=0, which re-arms the flag.
- State OVER: `run`=0. Scores and `match_winner` are held. On `start_rise`: same actions as from IDLE, then go to PLAY.
- BCD arithmetic: the ones digit increments; 9 wraps to 0 and carries into tens. BCD must always equal the binary score; no binary-to-BCD divider.
- Scores never exceed `WIN_SCORE`, so no wrap is possible.

## Timing
- Reset values: state IDLE, `run`=0, `new_match`=0, `point_pulse`=0, scores 0, BCD 8'h00, `match_winner`=0, `armed`=1, counter 0, `start_q`=0.
- All outputs are registered and change on the `clk` edge after the qualifying input is sampled; latency is 1 cycle from `pt` or `start_rise`.
- `run` falls on the edge that registers `pt`. If `tick` coincides with that edge it still passes, because `run` was 1 when sampled. The physics engine tolerates this: `game_over` stays latched until an enabled frame.
- `new_match` and `point_pulse` are exactly one `clk` wide.
- `tick` and `start_rise` in the same cycle in IDLE/OVER: the transition to PLAY happens. `run`=1 takes effect from the next cycle.
- `rst` mid-PAUSE or mid-OVER: the next edge returns to the reset values; any pending pause is discarded.
- A `valid` pulse while in PAUSE or OVER cannot score. It only updates `armed`.

## Test plan
- Reset then start pulse: `new_match` high 1 cycle, state=1, `run`=1, scores 0, BCD 00.
- Point for P1: `valid`&`game_over`, `winner`=1, with `game_over` held for 3 `valid` strobes. Required: `p1_score`=1 exactly once, one `point_pulse`, state=2, `run`=0.
- Pause count: `PAUSE_FRAMES`=4. Required: state returns to 1 on the 4th `tick`, not the 3rd. Ticks without physics activity do not re-arm.
- BCD carry: `WIN_SCORE`=12, award P2 ten points. Required: `p2_bcd`=8'h10 and `p2_score`=10. Awarding two more gives `match_winner`=2, state=3, `run`=0.
- Ignored winner: `pt` with `winner`=0 or 3 leaves scores unchanged, gives no `point_pulse`, and the state stays 1.
- Reset mid-PAUSE: all outputs return to reset values on the next edge. A subsequent `start` begins a clean match.
